// File: rtl/correlation_accumulator.sv
// Early/prompt/late I/Q integrator with a shared-squarer I^2+Q^2 back end.
// Define ACC_SATURATE_EN for symmetric saturating accumulators and acc_overflow.
module correlation_accumulator #(
  parameter int IN_WIDTH   = 4,
  parameter int ACC_WIDTH  = 16,
  parameter int ACC_LENGTH = 16368,
  parameter int I2Q2_WIDTH = 2 * ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  global_reset_n,
  input  logic                  frame_start,
  input  logic                  sample_valid,
  input  logic [IN_WIDTH-1:0]   early_i,
  input  logic [IN_WIDTH-1:0]   early_q,
  input  logic [IN_WIDTH-1:0]   prompt_i,
  input  logic [IN_WIDTH-1:0]   prompt_q,
  input  logic [IN_WIDTH-1:0]   late_i,
  input  logic [IN_WIDTH-1:0]   late_q,
  output logic                  accumulation_complete,
  output logic                  i2q2_valid,
  output logic [I2Q2_WIDTH-1:0] i2q2_early,
  output logic [I2Q2_WIDTH-1:0] i2q2_prompt,
  output logic [I2Q2_WIDTH-1:0] i2q2_late,
  output logic                  acc_overflow
);

  localparam int CW = $clog2(ACC_LENGTH + 1);
  localparam logic [CW-1:0] LAST = CW'(ACC_LENGTH);

`ifdef ACC_SATURATE_EN
  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {2'b00, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX;
`endif

  typedef enum logic {A_IDLE, A_ACCUM} acc_state_e;
  typedef enum logic [2:0] {
    S_IDLE, S_SQ0, S_SQ1, S_SQ2, S_SQ3, S_SQ4, S_SQ5, S_DONE
  } sq_state_e;

  // Returns {saturated, new accumulator value}.
  function automatic logic [ACC_WIDTH:0] add_op(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [IN_WIDTH-1:0]  p
  );
`ifdef ACC_SATURATE_EN
    logic signed [ACC_WIDTH:0] s;
    s = $signed({a[ACC_WIDTH-1], a}) + (ACC_WIDTH+1)'(p);
    if (s > SAT_MAX)
      return {1'b1, SAT_MAX[ACC_WIDTH-1:0]};
    else if (s < SAT_MIN)
      return {1'b1, SAT_MIN[ACC_WIDTH-1:0]};
    else
      return {1'b0, s[ACC_WIDTH-1:0]};
`else
    logic signed [ACC_WIDTH-1:0] w;
    w = a + ACC_WIDTH'(p);
    return {1'b0, w};
`endif
  endfunction

  acc_state_e acc_state_q, acc_state_d;
  sq_state_e  sq_state_q, sq_state_d;

  logic signed [IN_WIDTH-1:0]  prod [6];
  logic signed [ACC_WIDTH-1:0] acc_q [6];
  logic signed [ACC_WIDTH-1:0] acc_d [6];
  logic signed [ACC_WIDTH-1:0] snap_q [6];
  logic signed [ACC_WIDTH-1:0] snap_d [6];
  logic [5:0]    lane_ovf;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sticky_q, sticky_d;
  logic snap_ovf_q, snap_ovf_d;
  logic complete_q, complete_d;

  logic signed [ACC_WIDTH-1:0]   mul_a;
  logic signed [2*ACC_WIDTH-1:0] mul_x;
  logic signed [2*ACC_WIDTH-1:0] sq_full;
  logic [I2Q2_WIDTH-1:0] sq;
  logic [I2Q2_WIDTH-1:0] sum_e_q, sum_e_d;
  logic [I2Q2_WIDTH-1:0] sum_p_q, sum_p_d;
  logic [I2Q2_WIDTH-1:0] sum_l_q, sum_l_d;
  logic [I2Q2_WIDTH-1:0] out_e_q, out_e_d;
  logic [I2Q2_WIDTH-1:0] out_p_q, out_p_d;
  logic [I2Q2_WIDTH-1:0] out_l_q, out_l_d;
  logic valid_q, valid_d;
  logic ovf_q, ovf_d;

  always_comb begin
    prod[0] = early_i;
    prod[1] = early_q;
    prod[2] = prompt_i;
    prod[3] = prompt_q;
    prod[4] = late_i;
    prod[5] = late_q;
  end

  always_comb begin
    acc_state_d = acc_state_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    snap_ovf_d  = snap_ovf_q;
    complete_d  = 1'b0;
    lane_ovf    = '0;
    for (int i = 0; i < 6; i++) begin
      acc_d[i]  = acc_q[i];
      snap_d[i] = snap_q[i];
    end
    if (frame_start) begin
      acc_state_d = A_ACCUM;
      cnt_d = sample_valid ? CW'(1) : '0;
      for (int i = 0; i < 6; i++) begin
        if (sample_valid)
          {lane_ovf[i], acc_d[i]} = add_op('0, prod[i]);
        else
          acc_d[i] = '0;
      end
      sticky_d = |lane_ovf;
    end else if (acc_state_q == A_ACCUM && sample_valid) begin
      for (int i = 0; i < 6; i++)
        {lane_ovf[i], acc_d[i]} = add_op(acc_q[i], prod[i]);
      sticky_d = sticky_q | (|lane_ovf);
      cnt_d    = cnt_q + 1'b1;
      if (cnt_d == LAST) begin
        complete_d  = 1'b1;
        acc_state_d = A_IDLE;
        snap_ovf_d  = sticky_d;
        for (int i = 0; i < 6; i++)
          snap_d[i] = acc_d[i];
      end
    end
  end

  always_comb begin
    unique case (sq_state_q)
      S_SQ0:   mul_a = snap_q[0];
      S_SQ1:   mul_a = snap_q[1];
      S_SQ2:   mul_a = snap_q[2];
      S_SQ3:   mul_a = snap_q[3];
      S_SQ4:   mul_a = snap_q[4];
      S_SQ5:   mul_a = snap_q[5];
      default: mul_a = '0;
    endcase
    mul_x   = (2*ACC_WIDTH)'(mul_a);
    sq_full = mul_x * mul_x;
    sq      = I2Q2_WIDTH'($unsigned(sq_full));
  end

  // Results land on the SQ5 edge so i2q2_valid is high during DONE.
  always_comb begin
    sq_state_d = sq_state_q;
    sum_e_d    = sum_e_q;
    sum_p_d    = sum_p_q;
    sum_l_d    = sum_l_q;
    out_e_d    = out_e_q;
    out_p_d    = out_p_q;
    out_l_d    = out_l_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    unique case (sq_state_q)
      S_IDLE: if (complete_q) sq_state_d = S_SQ0;
      S_SQ0: begin
        sum_e_d    = sq;
        sq_state_d = S_SQ1;
      end
      S_SQ1: begin
        sum_e_d    = sum_e_q + sq;
        sq_state_d = S_SQ2;
      end
      S_SQ2: begin
        sum_p_d    = sq;
        sq_state_d = S_SQ3;
      end
      S_SQ3: begin
        sum_p_d    = sum_p_q + sq;
        sq_state_d = S_SQ4;
      end
      S_SQ4: begin
        sum_l_d    = sq;
        sq_state_d = S_SQ5;
      end
      S_SQ5: begin
        sum_l_d    = sum_l_q + sq;
        out_e_d    = sum_e_q;
        out_p_d    = sum_p_q;
        out_l_d    = sum_l_q + sq;
        ovf_d      = snap_ovf_q;
        valid_d    = 1'b1;
        sq_state_d = S_DONE;
      end
      default: sq_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      acc_state_q <= A_IDLE;
      sq_state_q  <= S_IDLE;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      snap_ovf_q  <= 1'b0;
      complete_q  <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        acc_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      sum_e_q <= '0;
      sum_p_q <= '0;
      sum_l_q <= '0;
      out_e_q <= '0;
      out_p_q <= '0;
      out_l_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      acc_state_q <= acc_state_d;
      sq_state_q  <= sq_state_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      snap_ovf_q  <= snap_ovf_d;
      complete_q  <= complete_d;
      for (int i = 0; i < 6; i++) begin
        acc_q[i]  <= acc_d[i];
        snap_q[i] <= snap_d[i];
      end
      sum_e_q <= sum_e_d;
      sum_p_q <= sum_p_d;
      sum_l_q <= sum_l_d;
      out_e_q <= out_e_d;
      out_p_q <= out_p_d;
      out_l_q <= out_l_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign accumulation_complete = complete_q;
  assign i2q2_valid            = valid_q;
  assign i2q2_early            = out_e_q;
  assign i2q2_prompt           = out_p_q;
  assign i2q2_late             = out_l_q;
  assign acc_overflow          = ovf_q;

endmodule

// File: tb/tb_correlation_accumulator.sv
// Bench for correlation_accumulator: two instances (16 and 32 sample frames)
// share stimulus; a frame-level reference model predicts every output.
module tb_correlation_accumulator;

  localparam int IW = 4;
  localparam int AW = 8;
  localparam int OW = 2 * AW;
  localparam int SATM = (1 << (AW - 1)) - 1;

`ifdef ACC_SATURATE_EN
  localparam longint T4_E = 16129;
  localparam longint T4_O = 1;
`else
  localparam longint T4_E = 1024;
  localparam longint T4_O = 0;
`endif

  typedef int prod_t [6];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic sample_valid = 1'b0;
  logic signed [IW-1:0] ei = '0, eq = '0, pi = '0, pq = '0, li = '0, lq = '0;

  logic          comp [2];
  logic          val  [2];
  logic [OW-1:0] oe   [2];
  logic [OW-1:0] op   [2];
  logic [OW-1:0] ol   [2];
  logic          ovf  [2];

  always #5 clk = ~clk;

  correlation_accumulator #(
    .IN_WIDTH(IW), .ACC_WIDTH(AW), .ACC_LENGTH(16), .I2Q2_WIDTH(OW)
  ) dut (
    .clk(clk), .global_reset_n(rst_n),
    .frame_start(frame_start), .sample_valid(sample_valid),
    .early_i(ei), .early_q(eq), .prompt_i(pi), .prompt_q(pq),
    .late_i(li), .late_q(lq),
    .accumulation_complete(comp[0]), .i2q2_valid(val[0]),
    .i2q2_early(oe[0]), .i2q2_prompt(op[0]), .i2q2_late(ol[0]),
    .acc_overflow(ovf[0])
  );

  correlation_accumulator #(
    .IN_WIDTH(IW), .ACC_WIDTH(AW), .ACC_LENGTH(32), .I2Q2_WIDTH(OW)
  ) dut32 (
    .clk(clk), .global_reset_n(rst_n),
    .frame_start(frame_start), .sample_valid(sample_valid),
    .early_i(ei), .early_q(eq), .prompt_i(pi), .prompt_q(pq),
    .late_i(li), .late_q(lq),
    .accumulation_complete(comp[1]), .i2q2_valid(val[1]),
    .i2q2_early(oe[1]), .i2q2_prompt(op[1]), .i2q2_late(ol[1]),
    .acc_overflow(ovf[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input longint exp);
    n_cmp++;
    if (got !== 64'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: running sums per frame, expected events by cycle.
  int     cyc = 0;
  int     lens [2] = '{16, 32};
  bit     act  [2];
  int     cnt  [2];
  int     acc  [2][6];
  bit     mo   [2];
  int     ccyc [2] = '{-1, -1};
  int     vcyc [2] = '{-1, -1};
  longint ve [2], vp [2], vl [2];
  bit     vo [2];
  longint he [2], hp [2], hl [2];
  bit     ho [2];

  function automatic int addf(input int a, input int p, output bit o);
    int s;
    s = a + p;
    o = 1'b0;
`ifdef ACC_SATURATE_EN
    if (s > SATM) begin s = SATM; o = 1'b1; end
    if (s < -SATM) begin s = -SATM; o = 1'b1; end
`else
    s = ((s + (1 << (AW - 1))) % (1 << AW) + (1 << AW)) % (1 << AW)
        - (1 << (AW - 1));
`endif
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int p [6];
    bit o;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        act[k] = 0; cnt[k] = 0; mo[k] = 0;
        ccyc[k] = -1; vcyc[k] = -1;
        he[k] = 0; hp[k] = 0; hl[k] = 0; ho[k] = 0;
      end
    end else begin
      cyc++;
      p = '{int'(ei), int'(eq), int'(pi), int'(pq), int'(li), int'(lq)};
      for (int k = 0; k < 2; k++) begin
        if (frame_start) begin
          act[k] = 1; cnt[k] = sample_valid ? 1 : 0; mo[k] = 0;
          for (int j = 0; j < 6; j++) acc[k][j] = sample_valid ? p[j] : 0;
        end else if (act[k] && sample_valid) begin
          for (int j = 0; j < 6; j++) begin
            acc[k][j] = addf(acc[k][j], p[j], o);
            mo[k] = mo[k] | o;
          end
          cnt[k]++;
          if (cnt[k] == lens[k]) begin
            act[k] = 0;
            ccyc[k] = cyc;
            vcyc[k] = cyc + 7;
            ve[k] = longint'(acc[k][0]) * acc[k][0] + longint'(acc[k][1]) * acc[k][1];
            vp[k] = longint'(acc[k][2]) * acc[k][2] + longint'(acc[k][3]) * acc[k][3];
            vl[k] = longint'(acc[k][4]) * acc[k][4] + longint'(acc[k][5]) * acc[k][5];
            vo[k] = mo[k];
          end
        end
        if (vcyc[k] == cyc) begin
          he[k] = ve[k]; hp[k] = vp[k]; hl[k] = vl[k]; ho[k] = vo[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d complete", k), comp[k], longint'(ccyc[k] == cyc));
      chk($sformatf("dut%0d i2q2_valid", k), val[k], longint'(vcyc[k] == cyc));
      chk($sformatf("dut%0d i2q2_early", k), oe[k], he[k]);
      chk($sformatf("dut%0d i2q2_prompt", k), op[k], hp[k]);
      chk($sformatf("dut%0d i2q2_late", k), ol[k], hl[k]);
      chk($sformatf("dut%0d acc_overflow", k), ovf[k], longint'(ho[k]));
    end
  end

  localparam prod_t Z = '{0, 0, 0, 0, 0, 0};

  task automatic drive(input bit fs, input bit sv, input prod_t v);
    @(posedge clk);
    #1;
    frame_start  = fs;
    sample_valid = sv;
    ei = IW'(v[0]); eq = IW'(v[1]); pi = IW'(v[2]);
    pq = IW'(v[3]); li = IW'(v[4]); lq = IW'(v[5]);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, Z);
  endtask

  task automatic frame(input int n, input prod_t v);
    drive(1, 1, v);
    repeat (n - 1) drive(0, 1, v);
  endtask

  task automatic wait_comp(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      drive(0, 0, Z);
      @(negedge clk);
      seen = comp[0];
    end
    chk({nm, " completion seen"}, seen, 1);
  endtask

  initial begin
    prod_t r;
    bit fs, sv;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset i2q2_early", oe[0], 0);
    chk("reset i2q2_valid", val[0], 0);
    chk("reset complete", comp[0], 0);
    rst_n = 1'b1;
    idle(2);

    // 16 x early_i=+1 -> 16^2
    frame(16, '{1, 0, 0, 0, 0, 0});
    idle(10);
    chk("t1 early", oe[0], 256);
    chk("t1 prompt", op[0], 0);
    chk("t1 late", ol[0], 0);

    // +3/-4 -> 48^2 + 64^2
    frame(16, '{0, 0, 3, -4, 0, 0});
    idle(10);
    chk("t2 prompt", op[0], 6400);
    chk("t2 early", oe[0], 0);

    // restart at sample 10, gaps in sample_valid
    frame(9, '{1, 0, 0, 0, 0, 0});
    drive(1, 1, '{0, 0, 0, 0, -2, 0});
    for (int i = 1; i < 16; i++) begin
      if (i % 4 == 0) drive(0, 0, Z);
      drive(0, 1, '{0, 0, 0, 0, -2, 0});
    end
    idle(10);
    chk("t3 late", ol[0], 1024);
    chk("t3 early", oe[0], 0);

    // 32 x +7 overflows an 8-bit accumulator
    frame(32, '{7, 0, 0, 0, 0, 0});
    idle(10);
    chk("t4 early", oe[1], T4_E);
    chk("t4 overflow", ovf[1], T4_O);

    // reset during SQ3
    frame(16, '{0, 1, 0, 0, 0, 2});
    wait_comp("t5");
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5 rst early", oe[0], 0);
    chk("t5 rst late", ol[0], 0);
    chk("t5 rst complete", comp[0], 0);
    chk("t5 rst valid", val[0], 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    chk("t5 no valid after reset", oe[0], 0);
    frame(16, '{0, 1, 0, 0, 0, 2});
    idle(10);
    chk("t5 new early", oe[0], 256);
    chk("t5 new late", ol[0], 1024);

    // frame_start lands in SQ1
    frame(16, '{0, 0, 2, 0, 0, 0});
    wait_comp("t6");
    drive(0, 0, Z);
    frame(16, '{0, -3, 0, 0, 5, 0});
    chk("t6 old prompt", op[0], 1024);
    chk("t6 old early", oe[0], 0);
    idle(10);
    chk("t6 new early", oe[0], 2304);
    chk("t6 new late", ol[0], 6400);
    chk("t6 new prompt", op[0], 0);

    for (int c = 0; c < 4000; c++) begin
      fs = ($urandom_range(0, 59) == 0);
      sv = ($urandom_range(0, 9) < 7);
      foreach (r[j]) r[j] = int'($urandom_range(0, 15)) - 8;
      drive(fs, sv, r);
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
